enemy_wave_scheduler: RTL and testbench
=======================================

Name: enemy_wave_scheduler

Overview:
- Sequences a bank of N_ENEMY enemy FSM+datapath slots.
- Generates the 60 Hz frame tick and spawns enemies on a timer into free slots.
- Issues staggered per-slot move pulses, one slot per cycle, so the shared draw datapath is never double-booked.
- Tracks score, lives and game-over; sits between the top-level game FSM and the enemy slot array.

Parameters:
N_ENEMY, 4, number of enemy slots (2..8)
FRAME_CYCLES, 833333, clk cycles per frame (50 MHz / 60)
SPAWN_FRAMES, 60, frames between spawn attempts
MOVE_FRAMES, 4, frames between move sweeps
LIVES_INIT, 3, lives loaded at game start (fits 2 bits)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle game start/restart pulse
slotInReset  in  N_ENEMY  per-slot inResetState from each enemy controller
bottomReached  in  N_ENEMY  per-slot bottom-of-screen flag
collidedWithBullet  in  N_ENEMY  per-slot bullet hit flag
enable  out  N_ENEMY  one-cycle spawn pulse per slot
updatePosition  out  N_ENEMY  one-cycle move pulse per slot
frameTick  out  1  one-cycle pulse at frame boundary
activeMask  out  N_ENEMY  slots currently owned/alive
score  out  8  kill count, saturating
lives  out  2  remaining lives
gameOver  out  1  high in S_GAME_OVER

Behaviour:
- One clock; reset is asynchronous and active-low (clk, resetn).
- Reset values: all outputs and counters 0; lives=0; state S_IDLE.
- All outputs are registered.
- FSM states:
  - S_IDLE: start -> S_RUN.
  - S_RUN: lives reaching 0 -> S_GAME_OVER.
  - S_GAME_OVER: start -> S_RUN.
- Entering S_RUN from start: frame, spawn and move counters=0; activeMask=0; score=0; lives=LIVES_INIT.
- start while already in S_RUN: ignored.
- Frame counter (S_RUN only): counts 0..FRAME_CYCLES-1 and wraps. frameTick=1 in the cycle after the counter holds FRAME_CYCLES-1.
- Spawn:
  - Spawn counter increments on each frameTick, saturating at SPAWN_FRAMES-1 (pending).
  - On a frameTick while pending, if free = slotInReset & ~activeMask is nonzero, choose the lowest-index free bit k.
  - Next cycle: enable[k]=1 for one cycle, activeMask[k] set, spawn counter cleared.
  - No free slot: stays pending and retries on every subsequent frameTick.
  - At most one spawn per frame.
- Move sweep:
  - Move counter counts frameTicks modulo MOVE_FRAMES; the sweep fires when it wraps to 0.
  - A snapshot of activeMask is taken in the frameTick cycle, before any spawn, so a slot spawned this frame is excluded.
  - updatePosition[k] pulses at cycle frameTick+1+k for each snapshot bit k; one bit max per cycle.
  - Sweep length is N_ENEMY cycles, well under FRAME_CYCLES; a new sweep never overlaps an old one. Assert FRAME_CYCLES > N_ENEMY+1.
- Retire (checked every S_RUN cycle, per slot with activeMask[k]=1):
  - collidedWithBullet[k]: clear activeMask[k]; score += 1, saturating at 255.
  - Else bottomReached[k]: clear activeMask[k]; lives -= 1, floor 0.
  - Both set on the same slot in the same cycle: collision wins, no life lost.
  - Multiple slots in the same cycle: score adds popcount(hits), saturating; lives subtracts popcount(bottoms), floored at 0.
  - Flags on inactive slots are ignored.
- Game over:
  - Lives reaching 0 moves the FSM to S_GAME_OVER on the next edge.
  - In S_GAME_OVER: enable and updatePosition are forced 0, counters freeze, gameOver=1, score holds its final value.
  - A sweep in progress is aborted.
- resetn low mid-sweep or mid-spawn: everything clears immediately; no pulse completes.

Decomposition:
- Package enemy_sched_pkg: state encoding (S_IDLE=2'd0, S_RUN=2'd1, S_GAME_OVER=2'd2), default parameter constants, counter width function (clog2).
- Sub-module frame_tick_gen: FRAME_CYCLES counter with run input and frameTick output. Lowest-free-slot priority encoder and popcount stay inline.

Test Plan (FRAME_CYCLES=8, SPAWN_FRAMES=2, MOVE_FRAMES=1, N_ENEMY=4, LIVES_INIT=3):
1. resetn low then high, start pulse, slotInReset=4'b1111 -> frameTick every 8 cycles; enable=4'b0001 one cycle after 2nd frameTick; activeMask=0001.
2. Continue with slotInReset tracking ~activeMask -> spawns go to slots 1, 2, 3 on every 2nd frame; with mask 0011, updatePosition[0] at tick+1 and [1] at tick+2; a slot spawned on tick T is not swept at T.
3. Mask=1111 for 4 frames -> spawn counter pending, no enable. Clear slot 2 via collidedWithBullet[2] -> score=1; enable[2] on the next frameTick+1.
4. Same cycle: collidedWithBullet=4'b0101, bottomReached=4'b0110, mask=1111 -> score+=2; lives 3->2 (slot 2 collision wins); mask=1000.
5. Three bottomReached events -> lives=0, gameOver=1 next cycle, no further enable/updatePosition. start -> score=0, lives=3, state S_RUN.
6. Assert resetn low at frameTick+2 during a sweep -> updatePosition=0 asynchronously; all outputs 0; state S_IDLE.

Source files
------------

// File: rtl/enemy_sched_pkg.sv
// Shared state encoding, default sizing and counter-width helper for the
// enemy wave scheduler.
package enemy_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RUN       = 2'd1,
      S_GAME_OVER = 2'd2
   } state_t;

   localparam int N_ENEMY_DEF      = 4;
   localparam int FRAME_CYCLES_DEF = 833333;
   localparam int SPAWN_FRAMES_DEF = 60;
   localparam int MOVE_FRAMES_DEF  = 4;
   localparam int LIVES_INIT_DEF   = 3;

   // Bits needed to hold 0..n-1; never less than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: one-cycle frameTick after the counter holds
// FRAME_CYCLES-1. Holds while run is low, restarts from zero on clr.
module frame_tick_gen
   import enemy_sched_pkg::*;
#(
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic run,
   output logic frameTick
);

   localparam int W = cnt_w(FRAME_CYCLES);
   localparam logic [W-1:0] LAST = W'(FRAME_CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count     <= '0;
         frameTick <= 1'b0;
      end else if (clr) begin
         count     <= '0;
         frameTick <= 1'b0;
      end else if (run) begin
         frameTick <= (count == LAST);
         count     <= (count == LAST) ? '0 : count + W'(1);
      end else begin
         frameTick <= 1'b0;
      end
   end

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Game-side sequencer for the enemy slot bank: frame tick, timed spawns into
// the lowest free slot, staggered move sweeps, and score/lives/game-over.
module enemy_wave_scheduler
   import enemy_sched_pkg::*;
#(
   parameter int N_ENEMY      = N_ENEMY_DEF,
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
   parameter int SPAWN_FRAMES = SPAWN_FRAMES_DEF,
   parameter int MOVE_FRAMES  = MOVE_FRAMES_DEF,
   parameter int LIVES_INIT   = LIVES_INIT_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [N_ENEMY-1:0] slotInReset,
   input  logic [N_ENEMY-1:0] bottomReached,
   input  logic [N_ENEMY-1:0] collidedWithBullet,
   output logic [N_ENEMY-1:0] enable,
   output logic [N_ENEMY-1:0] updatePosition,
   output logic               frameTick,
   output logic [N_ENEMY-1:0] activeMask,
   output logic [7:0]         score,
   output logic [1:0]         lives,
   output logic               gameOver
);

   localparam int SW = cnt_w(SPAWN_FRAMES);
   localparam int MW = cnt_w(MOVE_FRAMES);
   localparam logic [SW-1:0]      SPAWN_LAST = SW'(SPAWN_FRAMES - 1);
   localparam logic [MW-1:0]      MOVE_LAST  = MW'(MOVE_FRAMES - 1);
   localparam logic [N_ENEMY-1:0] SECOND     = N_ENEMY'(2);

   if (FRAME_CYCLES <= N_ENEMY + 1) begin : g_bad_frame
      $error("FRAME_CYCLES must exceed N_ENEMY+1 so sweeps never overlap");
   end
   if (N_ENEMY < 2 || N_ENEMY > 8) begin : g_bad_slots
      $error("N_ENEMY must be in 2..8");
   end

   state_t             state;
   logic [SW-1:0]      spawn_cnt;
   logic [MW-1:0]      move_cnt;
   logic [N_ENEMY-1:0] snap, walk;
   logic [N_ENEMY-1:0] hits, bots, free, lowest, spawn_bits;
   logic [3:0]         n_hits, n_bots, lives_left;
   logic [8:0]         score_sum;
   logic               alive, restart, sweep_fire;

   assign alive      = (state == S_RUN) && (lives != 2'd0);
   assign restart    = start && (state != S_RUN);
   assign hits       = collidedWithBullet & activeMask;
   // Collision wins over bottom on the same slot.
   assign bots       = bottomReached & activeMask & ~collidedWithBullet;
   assign free       = slotInReset & ~activeMask;
   assign sweep_fire = frameTick && (move_cnt == MOVE_LAST);
   assign spawn_bits = (frameTick && spawn_cnt == SPAWN_LAST) ? lowest : '0;
   assign score_sum  = {1'b0, score} + {5'd0, n_hits};
   assign lives_left = {2'b00, lives} - n_bots;

   always_comb begin
      lowest = '0;
      n_hits = '0;
      n_bots = '0;
      for (int i = N_ENEMY - 1; i >= 0; i--) begin
         if (free[i]) begin
            lowest    = '0;
            lowest[i] = 1'b1;
         end
      end
      for (int i = 0; i < N_ENEMY; i++) begin
         n_hits = n_hits + {3'd0, hits[i]};
         n_bots = n_bots + {3'd0, bots[i]};
      end
   end

   frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (restart),
      .run       (alive),
      .frameTick (frameTick)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= S_IDLE;
         spawn_cnt      <= '0;
         move_cnt       <= '0;
         snap           <= '0;
         walk           <= '0;
         enable         <= '0;
         updatePosition <= '0;
         activeMask     <= '0;
         score          <= '0;
         lives          <= '0;
         gameOver       <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (lives == 2'd0) begin
                  // Abort any spawn pulse or sweep on the way out.
                  state          <= S_GAME_OVER;
                  gameOver       <= 1'b1;
                  enable         <= '0;
                  updatePosition <= '0;
                  walk           <= '0;
               end else begin
                  enable     <= spawn_bits;
                  activeMask <= (activeMask & ~(hits | bots)) | spawn_bits;
                  score      <= score_sum[8] ? 8'hff : score_sum[7:0];
                  lives      <= (n_bots < {2'b00, lives}) ? lives_left[1:0] : 2'd0;
                  if (frameTick) begin
                     if (spawn_cnt != SPAWN_LAST) spawn_cnt <= spawn_cnt + SW'(1);
                     else if (spawn_bits != '0)   spawn_cnt <= '0;
                     move_cnt <= (move_cnt == MOVE_LAST) ? '0 : move_cnt + MW'(1);
                  end
                  // walk marks the slot whose pulse goes out next cycle.
                  if (sweep_fire) begin
                     snap           <= activeMask;
                     walk           <= SECOND;
                     updatePosition <= activeMask & N_ENEMY'(1);
                  end else begin
                     updatePosition <= snap & walk;
                     walk           <= walk << 1;
                  end
               end
            end
            default: begin
               if (start) begin
                  state          <= S_RUN;
                  spawn_cnt      <= '0;
                  move_cnt       <= '0;
                  snap           <= '0;
                  walk           <= '0;
                  enable         <= '0;
                  updatePosition <= '0;
                  activeMask     <= '0;
                  score          <= '0;
                  lives          <= 2'(LIVES_INIT);
                  gameOver       <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Bench for enemy_wave_scheduler: directed game scenario plus random play,
// checked every cycle against a cycle-indexed behavioural model.
module tb_enemy_wave_scheduler;

   localparam int N = 4, FC = 8, SF = 2, MF = 1, LI = 3;

   logic         clk = 1'b0;
   logic         resetn, start;
   logic [N-1:0] slotInReset, bottomReached, collidedWithBullet;
   logic [N-1:0] enable, updatePosition, activeMask;
   logic         frameTick, gameOver;
   logic [7:0]   score;
   logic [1:0]   lives;

   int   tests = 0, fails = 0;
   bit   chk_en = 1'b0, track = 1'b0;
   logic [N-1:0] sir_rand = '1;

   // Model: mode 0 idle, 1 run, 2 game over; due[k] = cycle index of move pulse.
   int   cyc = 0, rc = 0, m_spawn = 0, m_move = 0, m_score = 0, m_lives = 0, m_mode = 0;
   int   cur, kk;
   int   due[N];
   bit   m_tick = 1'b0;
   logic [N-1:0] m_mask = '0, m_en = '0, m_up = '0, h, b, fr, nm;

   enemy_wave_scheduler #(
      .N_ENEMY(N), .FRAME_CYCLES(FC), .SPAWN_FRAMES(SF),
      .MOVE_FRAMES(MF), .LIVES_INIT(LI)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .slotInReset(slotInReset), .bottomReached(bottomReached),
      .collidedWithBullet(collidedWithBullet),
      .enable(enable), .updatePosition(updatePosition), .frameTick(frameTick),
      .activeMask(activeMask), .score(score), .lives(lives), .gameOver(gameOver)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic void model_init();
      rc = 0; m_spawn = 0; m_move = 0; m_mask = '0; m_score = 0;
      m_tick = 1'b0; m_en = '0; m_up = '0;
      for (int i = 0; i < N; i++) due[i] = -1;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_mode = 0; m_lives = 0; cyc = 0;
         model_init();
      end else begin
         cur = cyc;
         cyc = cyc + 1;
         if (m_mode == 1 && m_lives > 0) begin
            h = collidedWithBullet & m_mask;
            b = bottomReached & m_mask & ~collidedWithBullet;
            m_score = m_score + $countones(h);
            if (m_score > 255) m_score = 255;
            m_lives = m_lives - $countones(b);
            if (m_lives < 0) m_lives = 0;
            nm = m_mask & ~(h | b);
            m_en = '0;
            if (m_tick) begin
               if (m_spawn == SF - 1) begin
                  fr = slotInReset & ~m_mask;
                  if (fr != '0) begin
                     kk = -1;
                     for (int i = 0; i < N; i++) if (fr[i] && kk < 0) kk = i;
                     m_en[kk] = 1'b1;
                     nm = nm | m_en;
                     m_spawn = 0;
                  end
               end else begin
                  m_spawn = m_spawn + 1;
               end
               m_move = (m_move + 1) % MF;
               if (m_move == 0)
                  for (int i = 0; i < N; i++) due[i] = m_mask[i] ? cur + 1 + i : -1;
            end
            m_mask = nm;
            rc = rc + 1;
            m_tick = (rc % FC == 0);
            for (int i = 0; i < N; i++) m_up[i] = (due[i] == cyc);
         end else if (m_mode == 1) begin
            m_mode = 2; m_en = '0; m_up = '0; m_tick = 1'b0;
            for (int i = 0; i < N; i++) due[i] = -1;
         end else begin
            m_tick = 1'b0; m_en = '0; m_up = '0;
            if (start) begin
               model_init();
               m_mode = 1; m_lives = LI;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("enable", int'(enable), int'(m_en));
         check("updatePosition", int'(updatePosition), int'(m_up));
         check("frameTick", int'(frameTick), int'(m_tick));
         check("activeMask", int'(activeMask), int'(m_mask));
         check("score", int'(score), m_score);
         check("lives", int'(lives), m_lives);
         check("gameOver", int'(gameOver), (m_mode == 2) ? 1 : 0);
      end
   end

   task automatic step();
      @(negedge clk);
      if (track) slotInReset = ~m_mask & sir_rand;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!frameTick && n < 40);
      if (!frameTick) check("tick_timeout", n, -1);
   endtask

   initial begin
      int n, pulses;
      bit found;
      resetn = 1'b1; start = 1'b0;
      slotInReset = '0; bottomReached = '0; collidedWithBullet = '0;
      #2 resetn = 1'b0;
      chk_en = 1'b1;
      step(); step();
      check("rst_lives", int'(lives), 0);
      check("rst_mask", int'(activeMask), 0);
      check("rst_gameover", int'(gameOver), 0);
      resetn = 1'b1;
      step();

      // First spawn lands one cycle after the second frame tick.
      slotInReset = 4'b1111; start = 1'b1;
      step(); start = 1'b0;
      check("run_lives", int'(lives), 3);
      wait_tick(n); check("tick1_latency", n, 8);
      wait_tick(n); check("tick2_latency", n, 8);
      step();
      check("spawn0_enable", int'(enable), 4'b0001);
      check("spawn0_mask", int'(activeMask), 4'b0001);

      // Slot spawned on a tick is not in that tick's sweep.
      track = 1'b1;
      wait_tick(n); wait_tick(n);
      step(); check("t4_up_slot0", int'(updatePosition), 4'b0001);
      step(); check("t4_new_slot_excluded", int'(updatePosition), 4'b0000);
      wait_tick(n);
      step(); check("t5_up_slot0", int'(updatePosition), 4'b0001);
      step(); check("t5_up_slot1", int'(updatePosition), 4'b0010);
      wait_tick(n); wait_tick(n); wait_tick(n);
      step(); check("full_mask", int'(activeMask), 4'b1111);

      // Full bank: spawn stays pending until a slot frees.
      repeat (4) wait_tick(n);
      step();
      collidedWithBullet = 4'b0100;
      step(); collidedWithBullet = '0;
      check("hit_score", int'(score), 1);
      check("hit_mask", int'(activeMask), 4'b1011);
      wait_tick(n);
      step(); check("respawn_slot2", int'(enable), 4'b0100);

      collidedWithBullet = 4'b0101; bottomReached = 4'b0110;
      step(); collidedWithBullet = '0; bottomReached = '0;
      check("multi_score", int'(score), 3);
      check("multi_lives", int'(lives), 2);
      check("multi_mask", int'(activeMask), 4'b1000);

      bottomReached = 4'b1000;
      step(); bottomReached = '0;
      check("bottom_lives", int'(lives), 1);
      n = 0;
      while (m_mask == '0 && n < 60) begin step(); n++; end
      if (m_mask == '0) check("respawn_timeout", n, -1);
      bottomReached = m_mask;
      step(); bottomReached = '0;
      check("last_life", int'(lives), 0);
      check("not_over_yet", int'(gameOver), 0);
      step(); check("game_over", int'(gameOver), 1);
      pulses = 0;
      repeat (40) begin
         step();
         if (enable != '0 || updatePosition != '0) pulses++;
      end
      check("go_quiet", pulses, 0);
      check("go_score_held", int'(score), 3);
      start = 1'b1;
      step(); start = 1'b0;
      check("restart_score", int'(score), 0);
      check("restart_lives", int'(lives), 3);
      check("restart_gameover", int'(gameOver), 0);

      // Random play with restarts.
      for (int i = 0; i < 2500; i++) begin
         sir_rand           = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
         collidedWithBullet = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
         bottomReached      = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
         start              = ($urandom_range(0, 149) == 0);
         step();
      end
      collidedWithBullet = '0; bottomReached = '0; sir_rand = '1;
      start = 1'b1;
      step(); start = 1'b0;

      // Reset asserted mid-sweep clears outputs without waiting for a clock.
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         step();
         if (frameTick && m_mask != '0 && m_mode == 1) found = 1'b1;
      end
      if (!found) check("sweep_timeout", 0, 1);
      step();
      @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      check("async_up", int'(updatePosition), 0);
      check("async_enable", int'(enable), 0);
      check("async_mask", int'(activeMask), 0);
      check("async_score", int'(score), 0);
      check("async_lives", int'(lives), 0);
      check("async_tick", int'(frameTick), 0);
      step(); step();
      resetn = 1'b1;
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
